// File: rtl/serial_alu_pkg.sv
// Shared encodings, FSM states and per-operation slice controls for serial_alu.
package serial_alu_pkg;

  localparam logic [1:0] MODE_LOGIC = 2'b00;
  localparam logic [1:0] MODE_ARITH = 2'b01;
  localparam logic [1:0] MODE_INC   = 2'b10;
  localparam logic [1:0] MODE_ILL   = 2'b11;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  // logic_sel: no carry chain, the carry flip-flop just holds its initial value
  typedef struct packed {
    logic invert_a;
    logic zero_b;
    logic cin;
    logic logic_sel;
  } ctrl_t;

  function automatic ctrl_t decode_op(input logic [1:0] mode, input logic [1:0] opcode);
    ctrl_t c;
    c = '0;
    case (mode)
      MODE_LOGIC: begin
        c.logic_sel = 1'b1;
        c.invert_a  = opcode[0];
        c.zero_b    = ~opcode[1];
      end
      MODE_ARITH: begin
        c.invert_a = opcode[0];
        if (!opcode[1]) begin
          // 0101 yields cout=1 as the inversion of {0,A}
          c.logic_sel = 1'b1;
          c.zero_b    = 1'b1;
          c.cin       = opcode[0];
        end
      end
      MODE_INC: begin
        c.cin      = 1'b1;
        c.invert_a = opcode[0];
        c.zero_b   = ~opcode[1];
      end
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/serial_alu_slice.sv
// Combinational 1-bit ALU slice reused every cycle by serial_alu.
module serial_alu_slice
  import serial_alu_pkg::*;
(
  input  logic  i_a,
  input  logic  i_b,
  input  logic  i_cin,
  input  ctrl_t i_ctrl,
  output logic  o_r,
  output logic  o_c
);

  logic w_a;
  logic w_b;

  assign w_a = i_a ^ i_ctrl.invert_a;
  assign w_b = i_b & ~i_ctrl.zero_b;

  always_comb begin
    o_r = w_a ^ w_b;
    o_c = i_cin;
    if (!i_ctrl.logic_sel) begin
      o_r = w_a ^ w_b ^ i_cin;
      o_c = (w_a & w_b) | (i_cin & (w_a ^ w_b));
    end
  end

endmodule

// File: rtl/serial_alu.sv
// Bit-serial WIDTH-bit ALU with start/busy/done handshake, LSB first.
// Optional overflow flag output o_ovf when SERIAL_ALU_OVF_EN is defined.
module serial_alu
  import serial_alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  input  logic             i_start,
  input  logic [1:0]       i_mode,
  input  logic [1:0]       i_opcode,
  input  logic [WIDTH-1:0] i_ain,
  input  logic [WIDTH-1:0] i_bin,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_result,
  output logic             o_cout,
  output logic             o_zero,
`ifdef SERIAL_ALU_OVF_EN
  output logic             o_ovf,
`endif
  output logic             o_err
);

  localparam int CNT_W = $clog2(WIDTH);

  state_t             r_state;
  ctrl_t              r_ctrl;
  logic               r_ill;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic [WIDTH-1:0]   r_sh;
  logic               r_carry;
  logic               r_cmsb;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_busy;
  logic               r_done;
  logic [WIDTH-1:0]   r_result;
  logic               r_cout;
  logic               r_zero;
  logic               r_err;
  logic               r_ovf;

  ctrl_t w_dec;
  logic  w_r;
  logic  w_c;

  assign w_dec = decode_op(i_mode, i_opcode);

  serial_alu_slice u_slice (
    .i_a   (r_a[0]),
    .i_b   (r_b[0]),
    .i_cin (r_carry),
    .i_ctrl(r_ctrl),
    .o_r   (w_r),
    .o_c   (w_c)
  );

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state  <= IDLE;
      r_ctrl   <= '0;
      r_ill    <= 1'b0;
      r_a      <= '0;
      r_b      <= '0;
      r_sh     <= '0;
      r_carry  <= 1'b0;
      r_cmsb   <= 1'b0;
      r_cnt    <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_result <= '0;
      r_cout   <= 1'b0;
      r_zero   <= 1'b0;
      r_err    <= 1'b0;
      r_ovf    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (i_start) begin
            r_busy  <= 1'b1;
            r_a     <= i_ain;
            r_b     <= i_bin;
            r_sh    <= '0;
            r_cnt   <= '0;
            r_ctrl  <= w_dec;
            r_carry <= w_dec.cin;
            r_ill   <= (i_mode == MODE_ILL);
            r_state <= (i_mode == MODE_ILL) ? DONE : RUN;
          end
        end
        RUN: begin
          r_sh    <= {w_r, r_sh[WIDTH-1:1]};
          r_a     <= {1'b0, r_a[WIDTH-1:1]};
          r_b     <= {1'b0, r_b[WIDTH-1:1]};
          r_carry <= w_c;
          r_cnt   <= r_cnt + CNT_W'(1);
          if (r_cnt == CNT_W'(WIDTH - 1)) begin
            // carry into the MSB, kept for overflow detection
            r_cmsb  <= r_carry;
            r_state <= DONE;
          end
        end
        DONE: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
          r_state <= IDLE;
          if (r_ill) begin
            r_result <= '0;
            r_cout   <= 1'b0;
            r_zero   <= 1'b1;
            r_err    <= 1'b1;
            r_ovf    <= 1'b0;
          end else begin
            r_result <= r_sh;
            r_cout   <= r_carry;
            r_zero   <= (r_sh == '0);
            r_err    <= 1'b0;
            r_ovf    <= r_cmsb ^ r_carry;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_busy   = r_busy;
  assign o_done   = r_done;
  assign o_result = r_result;
  assign o_cout   = r_cout;
  assign o_zero   = r_zero;
  assign o_err    = r_err;
`ifdef SERIAL_ALU_OVF_EN
  assign o_ovf    = r_ovf;
`else
  logic w_ovf_unused;
  assign w_ovf_unused = r_ovf;
`endif

endmodule

// File: tb/tb_serial_alu.sv
// Directed self-checking bench for serial_alu (WIDTH=8).
module tb_serial_alu;

  logic       clk;
  logic       reset_n;
  logic       start;
  logic [1:0] mode;
  logic [1:0] opcode;
  logic [7:0] ain;
  logic [7:0] bin;
  logic       busy;
  logic       done;
  logic [7:0] result;
  logic       cout;
  logic       zero;
  logic       err;
`ifdef SERIAL_ALU_OVF_EN
  logic       ovf;
`endif

  int n_checks = 0;
  int n_errors = 0;

  serial_alu #(.WIDTH(8)) dut (
    .i_clk    (clk),
    .i_reset_n(reset_n),
    .i_start  (start),
    .i_mode   (mode),
    .i_opcode (opcode),
    .i_ain    (ain),
    .i_bin    (bin),
    .o_busy   (busy),
    .o_done   (done),
    .o_result (result),
    .o_cout   (cout),
    .o_zero   (zero),
`ifdef SERIAL_ALU_OVF_EN
    .o_ovf    (ovf),
`endif
    .o_err    (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Issue one op, scramble operands after the start edge, wait for done.
  task automatic run_op(input logic [1:0] m, input logic [1:0] op,
                        input logic [7:0] a, input logic [7:0] b, input int exp_lat);
    int n;
    @(negedge clk);
    start = 1'b1; mode = m; opcode = op; ain = a; bin = b;
    @(posedge clk);
    #1;
    start = 1'b0; ain = ~a; bin = ~b;
    chk("busy_after_start", busy, 1);
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!done && n < 40);
    chk("latency", n, exp_lat);
    chk("busy_at_done", busy, 0);
  endtask

  task automatic chk_res(input string tag, input logic [7:0] r, input logic c,
                         input logic z, input logic e);
    chk({tag, "_result"}, result, r);
    chk({tag, "_cout"}, cout, c);
    chk({tag, "_zero"}, zero, z);
    chk({tag, "_err"}, err, e);
  endtask

  initial begin
    int seen_done;
    reset_n = 1'b0; start = 1'b0; mode = 2'b00; opcode = 2'b00; ain = 8'h00; bin = 8'h00;
    #12;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk_res("rst", 8'h00, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    reset_n = 1'b1;

    run_op(2'b01, 2'b10, 8'h3C, 8'h0F, 9);
    chk_res("add", 8'h4B, 1'b0, 1'b0, 1'b0);
`ifdef SERIAL_ALU_OVF_EN
    chk("add_ovf", ovf, 0);
`endif
    @(posedge clk);
    #1;
    chk("done_one_cycle", done, 0);
    chk("result_held", result, 8'h4B);

    run_op(2'b01, 2'b10, 8'hFF, 8'h01, 9);
    chk_res("carry", 8'h00, 1'b1, 1'b1, 1'b0);
`ifdef SERIAL_ALU_OVF_EN
    chk("carry_ovf", ovf, 0);
    run_op(2'b01, 2'b10, 8'h7F, 8'h01, 9);
    chk("ovf_result", result, 8'h80);
    chk("ovf_flag", ovf, 1);
`endif

    run_op(2'b10, 2'b01, 8'h01, 8'h00, 9);
    chk_res("neg", 8'hFF, 1'b0, 1'b0, 1'b0);
    run_op(2'b10, 2'b11, 8'h03, 8'h05, 9);
    chk_res("sub", 8'h02, 1'b1, 1'b0, 1'b0);
    run_op(2'b10, 2'b00, 8'hFF, 8'h55, 9);
    chk_res("inc", 8'h00, 1'b1, 1'b1, 1'b0);
    run_op(2'b10, 2'b10, 8'h10, 8'h20, 9);
    chk_res("addc", 8'h31, 1'b0, 1'b0, 1'b0);
    run_op(2'b01, 2'b11, 8'h01, 8'h03, 9);
    chk_res("nota_b", 8'h01, 1'b1, 1'b0, 1'b0);
    run_op(2'b01, 2'b01, 8'h0F, 8'h00, 9);
    chk_res("inva", 8'hF0, 1'b1, 1'b0, 1'b0);
`ifdef SERIAL_ALU_OVF_EN
    chk("inva_ovf", ovf, 0);
`endif

    run_op(2'b11, 2'b10, 8'h12, 8'h34, 1);
    chk_res("illegal", 8'h00, 1'b0, 1'b1, 1'b1);
    run_op(2'b00, 2'b10, 8'hAA, 8'h0F, 9);
    chk_res("xor", 8'hA5, 1'b0, 1'b0, 1'b0);
    run_op(2'b00, 2'b11, 8'hAA, 8'h0F, 9);
    chk_res("xnor", 8'h5A, 1'b0, 1'b0, 1'b0);
    run_op(2'b00, 2'b01, 8'h00, 8'hFF, 9);
    chk_res("nota", 8'hFF, 1'b0, 1'b0, 1'b0);

    // start re-asserted mid-RUN with other operands must be ignored
    @(negedge clk);
    start = 1'b1; mode = 2'b01; opcode = 2'b10; ain = 8'h3C; bin = 8'h0F;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    start = 1'b1; mode = 2'b00; opcode = 2'b00; ain = 8'h11; bin = 8'h22;
    repeat (2) @(negedge clk);
    start = 1'b0;
    seen_done = 0;
    for (int i = 0; i < 20 && seen_done == 0; i++) begin
      @(negedge clk);
      if (done) seen_done = 1;
    end
    chk("ignore_start_done", seen_done, 1);
    chk("ignore_start_result", result, 8'h4B);
    repeat (3) @(negedge clk);

    // reset in the middle of RUN
    @(negedge clk);
    start = 1'b1; mode = 2'b01; opcode = 2'b10; ain = 8'h10; bin = 8'h01;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_result", result, 8'h00);
    @(negedge clk);
    reset_n = 1'b1;
    seen_done = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done) seen_done = 1;
    end
    chk("abort_no_done", seen_done, 0);
    run_op(2'b01, 2'b10, 8'h10, 8'h01, 9);
    chk_res("after_reset", 8'h11, 1'b0, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
